// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side drain controller for a FIFO. Pulls words from the FIFO only
// when it is not empty, and presents them on a valid/ready stream through
// a 2-entry skid buffer at one word per cycle. A flush mode empties the
// buffer and the FIFO without presenting data.
//
// Ports:
//   clk_i, rst_n_i        clock (FIFO read clock), async active-low reset
//   enable_i              level, permits reads in normal operation
//   flush_i               one-cycle pulse, discard buffer and FIFO contents
//   rd_en_o               FIFO read strobe (data returns one cycle later)
//   rdata_i               FIFO read data
//   empty_i, rd_error_i   FIFO empty flag and read-underflow indication
//   m_data_o, m_valid_o   stream output (head of the skid buffer)
//   m_ready_i             stream ready
//   busy_o                not idle, or the buffer holds words
//   flush_done_o          one-cycle pulse when a flush completes
//   rd_count_o            words delivered on the stream (wraps)
//   drop_count_o          words discarded by flush (wraps)
//   err_o                 sticky read-error flag, cleared only by reset
module fifo_rd_stream #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 flush_i,
  output logic                 rd_en_o,
  input  logic [WIDTH-1:0]     rdata_i,
  input  logic                 empty_i,
  input  logic                 rd_error_i,
  output logic [WIDTH-1:0]     m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 busy_o,
  output logic                 flush_done_o,
  output logic [CNT_WIDTH-1:0] rd_count_o,
  output logic [CNT_WIDTH-1:0] drop_count_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [1:0]           occ_r;
  logic [1:0]           occ_s;
  logic                 inflight_r;
  logic [WIDTH-1:0]     head_r;
  logic [WIDTH-1:0]     head_s;
  logic [WIDTH-1:0]     tail_r;
  logic [WIDTH-1:0]     tail_s;
  // Words owed to drop_count_o: the counter moves by at most one per cycle,
  // so discarded buffer entries and arriving words queue up here.
  logic [1:0]           pend_r;
  logic [1:0]           pend_s;
  logic [1:0]           owed_s;
  logic                 m_valid_r;
  logic                 busy_r;
  logic                 flush_done_r;
  logic                 err_r;
  logic [CNT_WIDTH-1:0] rd_count_r;
  logic [CNT_WIDTH-1:0] drop_count_r;
  logic                 pop_s;
  logic                 push_s;
  logic                 drop_s;
  logic                 flush_start_s;
  logic                 rd_en_s;
  logic [2:0]           room_s;

  assign pop_s = m_valid_r && m_ready_i;

  // FIFO read strobe: only when the FIFO has data and, in RUN, the buffer
  // plus the word in flight (less this cycle's pop) leaves a free slot.
  always_comb begin
    rd_en_s = 1'b0;
    room_s  = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    case (state_r)
      ST_IDLE: rd_en_s = 1'b0;
      ST_RUN: begin
        if (enable_i && !empty_i && (room_s < 3'd2)) begin
          rd_en_s = 1'b1;
        end else begin
          rd_en_s = 1'b0;
        end
      end
      ST_FLUSH: rd_en_s = !empty_i;
      default:  rd_en_s = 1'b0;
    endcase
  end

  // Next state, skid-buffer update and flush drop bookkeeping
  always_comb begin
    state_s       = state_r;
    occ_s         = occ_r;
    head_s        = head_r;
    tail_s        = tail_r;
    pend_s        = pend_r;
    push_s        = 1'b0;
    drop_s        = 1'b0;
    owed_s        = 2'd0;
    flush_start_s = flush_i && (state_r != ST_FLUSH);

    case (state_r)
      ST_IDLE: begin
        if (flush_i) begin
          state_s = ST_FLUSH;
        end else if (enable_i) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_s = ST_FLUSH;
        end else if (!enable_i && !inflight_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Leave only once nothing is left to read, arrive or be counted.
        if (empty_i && !inflight_r && (pend_r <= 2'd1)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    if (flush_start_s) begin
      // Unpopped entries and a word arriving this cycle are all discarded.
      occ_s  = 2'd0;
      pend_s = occ_r - {1'b0, pop_s} + {1'b0, inflight_r};
    end else if (state_r == ST_FLUSH) begin
      owed_s = pend_r + {1'b0, inflight_r};
      if (owed_s != 2'd0) begin
        drop_s = 1'b1;
        pend_s = owed_s - 2'd1;
      end else begin
        drop_s = 1'b0;
        pend_s = 2'd0;
      end
    end else begin
      push_s = inflight_r;
      case ({push_s, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            head_s = rdata_i;
          end else begin
            tail_s = rdata_i;
          end
          occ_s = occ_r + 2'd1;
        end
        2'b01: begin
          head_s = tail_r;
          occ_s  = occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            head_s = rdata_i;
          end else begin
            head_s = tail_r;
            tail_s = rdata_i;
          end
        end
        default: occ_s = occ_r;
      endcase
    end
  end

  // Control state, buffer storage and read-in-flight tracking
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= ST_IDLE;
      occ_r      <= 2'd0;
      head_r     <= '0;
      tail_r     <= '0;
      pend_r     <= 2'd0;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      occ_r      <= occ_s;
      head_r     <= head_s;
      tail_r     <= tail_s;
      pend_r     <= pend_s;
      inflight_r <= rd_en_s;
    end
  end

  // Registered status flags, derived from the next-cycle state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_valid_r    <= 1'b0;
      busy_r       <= 1'b0;
      flush_done_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      m_valid_r    <= (occ_s != 2'd0);
      busy_r       <= (state_s != ST_IDLE) || (occ_s != 2'd0);
      flush_done_r <= (state_r == ST_FLUSH) && (state_s == ST_IDLE);
      err_r        <= err_r || rd_error_i;
    end
  end

  // Delivered and dropped word counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_count_r   <= '0;
      drop_count_r <= '0;
    end else begin
      if (pop_s) begin
        rd_count_r <= rd_count_r + CNT_WIDTH'(1);
      end
      if (drop_s) begin
        drop_count_r <= drop_count_r + CNT_WIDTH'(1);
      end
    end
  end

  assign rd_en_o      = rd_en_s;
  assign m_data_o     = head_r;
  assign m_valid_o    = m_valid_r;
  assign busy_o       = busy_r;
  assign flush_done_o = flush_done_r;
  assign rd_count_o   = rd_count_r;
  assign drop_count_o = drop_count_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream. A behavioural FIFO with one-cycle read
// latency feeds the DUT; expected stream words go into a queue when the
// FIFO is loaded and are popped as the DUT delivers beats.
module tb_fifo_rd_stream;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic        rd_en;
  logic [7:0]  rdata;
  logic        empty;
  logic        rd_error;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        flush_done;
  logic [15:0] rd_count;
  logic [15:0] drop_count;
  logic        err;

  int tests;
  int fails;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  // FIFO model
  logic [7:0] mem [0:1023];
  int wr_ptr;
  int rd_ptr;
  assign empty = (rd_ptr == wr_ptr);

  // Monitor totals, sampled mid-cycle
  int iss_tot;
  int del_tot;
  int viol;

  fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .flush_i      (flush),
    .rd_en_o      (rd_en),
    .rdata_i      (rdata),
    .empty_i      (empty),
    .rd_error_i   (rd_error),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .busy_o       (busy),
    .flush_done_o (flush_done),
    .rd_count_o   (rd_count),
    .drop_count_o (drop_count),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en && !empty) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (rd_en) iss_tot <= iss_tot + 1;
    if (rd_en && empty) viol <= viol + 1;
    if (m_valid && m_ready) del_tot <= del_tot + 1;
  end

  task automatic push_words(input logic [7:0] base, input int n, input bit track);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = base + 8'(i);
      if (track) exp_q.push_back(base + 8'(i));
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; rd_error = 1'b0; m_ready = 1'b0;
    #12;
    tests++;
    if ({m_valid, rd_en, busy, flush_done, err} !== 5'b00000) begin
      fails++; $display("FAIL reset_flags: got %b want 00000", {m_valid, rd_en, busy, flush_done, err});
    end
    tests++;
    if (m_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", m_data); end
    tests++;
    if (rd_count !== 16'd0 || drop_count !== 16'd0) begin
      fails++; $display("FAIL reset_counts: got %0d/%0d want 0/0", rd_count, drop_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      fails++; $display("FAIL reset_idle: busy %b valid %b want 0 0", busy, m_valid);
    end
  endtask

  task automatic test_stream();
    int first = -1;
    int last = -1;
    int beats = 0;
    push_words(8'h11, 8, 1'b1);
    enable = 1'b1; m_ready = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL stream_beat: got %h, none expected", m_data); end
        else begin
          exp_w = exp_q.pop_front();
          if (m_data !== exp_w) begin fails++; $display("FAIL stream_beat: got %h want %h", m_data, exp_w); end
        end
        beats++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk); #1;
    end
    tests++;
    if (first != 4) begin fails++; $display("FAIL stream_latency: first beat cycle %0d want 4", first); end
    tests++;
    if (beats != 8 || last - first != 7) begin
      fails++; $display("FAIL stream_bubbles: beats %0d span %0d want 8 7", beats, last - first);
    end
    tests++;
    if (rd_count !== 16'd8) begin fails++; $display("FAIL stream_count: got %0d want 8", rd_count); end
    tests++;
    if (viol != 0) begin fails++; $display("FAIL stream_rd_empty: got %0d want 0", viol); end
  endtask

  task automatic test_backpressure();
    int i0;
    m_ready = 1'b0;
    i0 = iss_tot;
    push_words(8'h11, 8, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        tests++; fails++; $display("FAIL bp_beat: got beat %h while not ready, want none", m_data);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (iss_tot - i0 != 2) begin fails++; $display("FAIL bp_reads: got %0d want 2", iss_tot - i0); end
    tests++;
    if (m_valid !== 1'b1 || m_data !== 8'h11) begin
      fails++; $display("FAIL bp_hold: valid %b data %h want 1 11", m_valid, m_data);
    end
    m_ready = 1'b1;
    #1;
    tests++;
    if (rd_en !== 1'b1) begin fails++; $display("FAIL bp_resume: rd_en %b want 1", rd_en); end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL bp_beat: got %h, none expected", m_data); end
        else begin
          exp_w = exp_q.pop_front();
          if (m_data !== exp_w) begin fails++; $display("FAIL bp_beat: got %h want %h", m_data, exp_w); end
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (exp_q.size() != 0 || rd_count !== 16'd16) begin
      fails++; $display("FAIL bp_drain: left %0d count %0d want 0 16", exp_q.size(), rd_count);
    end
  endtask

  task automatic test_random();
    int i0;
    int d0;
    int cyc = 0;
    int max_out = 0;
    i0 = iss_tot; d0 = del_tot;
    for (int i = 0; i < 200; i++) begin
      mem[wr_ptr] = 8'($urandom_range(0, 255));
      exp_q.push_back(mem[wr_ptr]);
      wr_ptr = wr_ptr + 1;
    end
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        tests++;
        exp_w = exp_q.pop_front();
        if (m_data !== exp_w) begin fails++; $display("FAIL rand_beat: got %h want %h", m_data, exp_w); end
      end
      @(posedge clk); #1;
      if ((iss_tot - i0) - (del_tot - d0) > max_out) max_out = (iss_tot - i0) - (del_tot - d0);
      m_ready = ($urandom_range(0, 1) == 1);
      cyc++;
    end
    m_ready = 1'b1;
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL rand_timeout: %0d words left want 0", exp_q.size()); end
    tests++;
    if (rd_count !== 16'd216) begin fails++; $display("FAIL rand_count: got %0d want 216", rd_count); end
    tests++;
    if (max_out > 2) begin fails++; $display("FAIL rand_occupancy: got %0d want <= 2", max_out); end
    tests++;
    if (viol != 0) begin fails++; $display("FAIL rand_rd_empty: got %0d want 0", viol); end
  endtask

  task automatic test_flush();
    int pulses = 0;
    int vbad = 0;
    m_ready = 1'b0;
    push_words(8'hA0, 12, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    tests++;
    if (m_valid !== 1'b1 || m_data !== 8'hA0) begin
      fails++; $display("FAIL flush_pre: valid %b data %h want 1 a0", m_valid, m_data);
    end
    flush = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (flush_done === 1'b1) pulses++;
      if (m_valid !== 1'b0) vbad++;
      @(posedge clk); #1;
    end
    tests++;
    if (drop_count !== 16'd12) begin fails++; $display("FAIL flush_drops: got %0d want 12", drop_count); end
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL flush_done: got %0d pulses want 1", pulses); end
    tests++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || vbad != 0) begin
      fails++; $display("FAIL flush_idle: busy %b valid %b vbad %0d want 0 0 0", busy, m_valid, vbad);
    end
    tests++;
    if (rd_ptr != wr_ptr || rd_count !== 16'd216) begin
      fails++; $display("FAIL flush_fifo: left %0d count %0d want 0 216", wr_ptr - rd_ptr, rd_count);
    end
  endtask

  task automatic test_error();
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_pre: got %b want 0", err); end
    rd_error = 1'b1;
    @(posedge clk); #1;
    rd_error = 1'b0;
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", err); end
    repeat (5) begin @(posedge clk); #1; end
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_async_reset();
    int rem;
    m_ready = 1'b1; enable = 1'b1;
    push_words(8'h30, 10, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        tests++;
        exp_w = exp_q.pop_front();
        if (m_data !== exp_w) begin fails++; $display("FAIL arst_pre_beat: got %h want %h", m_data, exp_w); end
      end
      @(posedge clk); #1;
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({m_valid, rd_en, busy, flush_done, err} !== 5'b00000) begin
      fails++; $display("FAIL arst_flags: got %b want 00000", {m_valid, rd_en, busy, flush_done, err});
    end
    tests++;
    if (m_data !== 8'h00 || rd_count !== 16'd0 || drop_count !== 16'd0) begin
      fails++; $display("FAIL arst_values: data %h counts %0d/%0d want 00 0/0", m_data, rd_count, drop_count);
    end
    exp_q.delete();
    for (int p = rd_ptr; p < wr_ptr; p++) exp_q.push_back(mem[p]);
    rem = wr_ptr - rd_ptr;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        tests++;
        exp_w = exp_q.pop_front();
        if (m_data !== exp_w) begin fails++; $display("FAIL arst_beat: got %h want %h", m_data, exp_w); end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (exp_q.size() != 0 || rd_count !== 16'(rem)) begin
      fails++; $display("FAIL arst_resume: left %0d count %0d want 0 %0d", exp_q.size(), rd_count, rem);
    end
    tests++;
    if (viol != 0) begin fails++; $display("FAIL arst_rd_empty: got %0d want 0", viol); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_flush();
    test_error();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
